jtag_er1_dr: RTL and testbench
==============================

Name: jtag_er1_dr

Overview:
- User data register behind the ECP5 JTAGG ER1 instruction. Runs entirely in the JTCK domain.
- Captures a status word, shifts TDI/TDO, and checks the scan length on update.
- Latches a validated payload onto data_out for the LED/RGB display logic downstream.
- Supplies JTDO1 back to the JTAGG primitive, so OpenOCD `drscan` reads back status.

Parameters:
- DR_WIDTH, 16, number of bits in the shift register and in data_out.
- CNT_WIDTH, 8, width of the good-update and error counters.

Ports:
- jtck, input, 1, JTAG test clock from JTAGG JTCK. Sole clock.
- jrstn, input, 1, asynchronous active-low reset from JTAGG JTRSTN.
- jce1, input, 1, ER1 selected and in Capture-DR or Shift-DR.
- jshift, input, 1, TAP in Shift-DR.
- jupdate, input, 1, TAP in Update-DR.
- jtdi, input, 1, serial data in.
- jtdo1, output, 1, serial data out to JTAGG JTDO1.
- data_out, output, DR_WIDTH, last accepted payload.
- data_valid, output, 1, one-jtck pulse when data_out changes.
- good_cnt, output, CNT_WIDTH, number of accepted updates.
- err_cnt, output, CNT_WIDTH, number of rejected updates.
- len_err, output, 1, sticky flag: last update was rejected.

Behaviour:
- Reset (jrstn low, asynchronous): all outputs are 0, and so are sr, bit_cnt, armed, good_cnt, err_cnt, len_err and data_out. Deassertion takes effect on the next jtck rising edge.
- Phase decode per posedge jtck:
  - capture = jce1 & !jshift.
  - shift = jce1 & jshift.
  - update = jupdate & armed.
- armed:
  - Set on capture.
  - Cleared on update.
  - Without it, jupdate from another instruction is ignored.
- Capture:
  - sr <= {err_cnt[3:0], good_cnt[3:0], len_err, zero-fill} packed LSB-first into DR_WIDTH.
  - bit_cnt <= 0.
- Shift:
  - sr <= {jtdi, sr[DR_WIDTH-1:1]}, i.e. LSB shifted out first.
  - bit_cnt increments and saturates at all-ones, width clog2(DR_WIDTH)+2.
- jtdo1 = sr[0], combinational from the register, so it is valid for the TAP's negedge sampling.
- Update when bit_cnt == DR_WIDTH:
  - data_out <= sr; data_valid = 1 for one cycle.
  - good_cnt++ (wraps); len_err <= 0.
- Update when bit_cnt != DR_WIDTH (short, long, or zero shifts):
  - data_out is held; no data_valid.
  - err_cnt++ (wraps); len_err <= 1.
- data_valid is 0 in every cycle with no accepted update.
- Capture with no intervening update simply re-arms: sr is reloaded and bit_cnt cleared.
- Both counters wrap from all-ones to 0.
- Reset mid-shift: partial data is lost, data_out returns to 0, armed is cleared.

Optional Feature:
- Macro: JTAG_ER1_PARITY_EN.
- When defined:
  - Expected scan length becomes DR_WIDTH+1; sr and bit_cnt are sized accordingly.
  - The last bit shifted (sr[DR_WIDTH]) is an odd-parity bit over sr[DR_WIDTH-1:0].
  - An update is accepted only if the length is correct and parity is odd.
  - A parity failure is treated exactly like a length error.
  - The capture status word gets bit DR_WIDTH = 1.
- When undefined: the behaviour described above.

Test Plan:
- Reset, then capture, then shift 16 bits of 0xA5C3 LSB-first, then update -> data_out = 0xA5C3, one data_valid pulse, good_cnt = 1, len_err = 0.
- Second capture, then shift 16 zeros -> jtdo1 sequence LSB-first is the status word, with good_cnt nibble = 1 and err_cnt nibble = 0.
- Capture, shift 12 bits, update -> data_out still 0xA5C3, no data_valid, err_cnt = 1, len_err = 1. A following correct 16-bit scan of 0x0001 -> data_out = 0x0001, len_err = 0.
- jupdate pulse with no prior capture (armed = 0) -> no counter or output change.
- Shift 20 bits, then update -> rejected, err_cnt increments. Drop jrstn mid-shift -> all outputs 0 immediately, without waiting for a jtck edge.
- With JTAG_ER1_PARITY_EN:
  - 0x0003 followed by parity bit 1 -> accepted.
  - 0x0003 followed by parity bit 0 -> rejected, len_err = 1.

Source files
------------

// File: rtl/jtag_er1_dr.sv
// ER1 user data register in the JTCK domain: captures status, shifts TDI/TDO, validates scan length on update.
// Optional JTAG_ER1_PARITY_EN: one extra odd-parity bit is shifted last and checked before accepting.
module jtag_er1_dr #(
  parameter int DR_WIDTH  = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 jtck,
  input  logic                 jrstn,
  input  logic                 jce1,
  input  logic                 jshift,
  input  logic                 jupdate,
  input  logic                 jtdi,
  output logic                 jtdo1,
  output logic [DR_WIDTH-1:0]  data_out,
  output logic                 data_valid,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 len_err
);

`ifdef JTAG_ER1_PARITY_EN
  localparam int SR_W = DR_WIDTH + 1;
`else
  localparam int SR_W = DR_WIDTH;
`endif
  localparam int BC_W = $clog2(SR_W) + 2;
  localparam logic [BC_W-1:0] BC_MAX = '1;
  localparam logic [BC_W-1:0] BC_LEN = BC_W'(SR_W);

  logic [SR_W-1:0]      sr_q, sr_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 armed_q, armed_d;
  logic [DR_WIDTH-1:0]  data_q, data_d;
  logic                 dv_q, dv_d;
  logic [CNT_WIDTH-1:0] good_q, good_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic                 len_err_q, len_err_d;

  logic            capture, shift, update, accept;
  logic [SR_W-1:0] status;

  assign capture = jce1 & ~jshift;
  assign shift   = jce1 & jshift;
  assign update  = jupdate & armed_q;

  // Status word read back by drscan; needs DR_WIDTH >= 9 and CNT_WIDTH >= 4.
  always_comb begin
    status      = '0;
    status[3:0] = err_q[3:0];
    status[7:4] = good_q[3:0];
    status[8]   = len_err_q;
`ifdef JTAG_ER1_PARITY_EN
    status[DR_WIDTH] = 1'b1;
`endif
  end

`ifdef JTAG_ER1_PARITY_EN
  assign accept = (bit_cnt_q == BC_LEN) & (^sr_q);
`else
  assign accept = (bit_cnt_q == BC_LEN);
`endif

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    armed_d   = armed_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    good_d    = good_q;
    err_d     = err_q;
    len_err_d = len_err_q;

    if (update) begin
      armed_d = 1'b0;
      if (accept) begin
        data_d    = sr_q[DR_WIDTH-1:0];
        dv_d      = 1'b1;
        good_d    = good_q + CNT_WIDTH'(1);
        len_err_d = 1'b0;
      end else begin
        err_d     = err_q + CNT_WIDTH'(1);
        len_err_d = 1'b1;
      end
    end

    if (capture) begin
      sr_d      = status;
      bit_cnt_d = '0;
      armed_d   = 1'b1;
    end else if (shift) begin
      sr_d = {jtdi, sr_q[SR_W-1:1]};
      if (bit_cnt_q != BC_MAX) bit_cnt_d = bit_cnt_q + BC_W'(1);
    end
  end

  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      good_q    <= '0;
      err_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      good_q    <= good_d;
      err_q     <= err_d;
      len_err_q <= len_err_d;
    end
  end

  // LSB straight from the register so the TAP can sample it on the falling edge.
  assign jtdo1      = sr_q[0];
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign good_cnt   = good_q;
  assign err_cnt    = err_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_jtag_er1_dr.sv
// Bench for jtag_er1_dr: directed and random scans against a bit-stream reference model.
module tb_jtag_er1_dr;
  localparam int W = 16;
`ifdef JTAG_ER1_PARITY_EN
  localparam int LEN = W + 1;
`else
  localparam int LEN = W;
`endif

  logic jtck = 1'b0;
  logic jrstn, jce1, jshift, jupdate, jtdi;
  logic jtdo1, data_valid, len_err;
  logic [W-1:0] data_out;
  logic [7:0] good_cnt, err_cnt;

  jtag_er1_dr #(.DR_WIDTH(W), .CNT_WIDTH(8)) dut (
    .jtck(jtck), .jrstn(jrstn), .jce1(jce1), .jshift(jshift), .jupdate(jupdate),
    .jtdi(jtdi), .jtdo1(jtdo1), .data_out(data_out), .data_valid(data_valid),
    .good_cnt(good_cnt), .err_cnt(err_cnt), .len_err(len_err)
  );

  always #5 jtck = ~jtck;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_data;
  logic [7:0]   m_good, m_err;
  logic         m_len, m_armed;
  bit           tx_bits[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_dv);
    check({tag, ".data_out"},   32'(data_out),   32'(m_data));
    check({tag, ".data_valid"}, 32'(data_valid), 32'(exp_dv));
    check({tag, ".good_cnt"},   32'(good_cnt),   32'(m_good));
    check({tag, ".err_cnt"},    32'(err_cnt),    32'(m_err));
    check({tag, ".len_err"},    32'(len_err),    32'(m_len));
  endtask

  // Inputs change on the falling edge; the DUT samples on the following rising edge.
  task automatic cyc(input logic ce, input logic sh, input logic up, input logic tdi);
    jce1 = ce; jshift = sh; jupdate = up; jtdi = tdi;
    @(negedge jtck);
  endtask

  task automatic model_reset();
    m_data = '0; m_good = '0; m_err = '0; m_len = 1'b0; m_armed = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] d, input bit flip_par);
    for (int i = 0; i < 64; i++) tx_bits[i] = bit'($urandom_range(0, 1));
    for (int i = 0; i < W; i++) tx_bits[i] = d[i];
`ifdef JTAG_ER1_PARITY_EN
    tx_bits[W] = (~^d) ^ flip_par;
`else
    if (flip_par) tx_bits[0] = d[0];
`endif
  endtask

  task automatic scan(input string tag, input int n, input bit do_update);
    logic [63:0] st;
    logic        exp_bit;
    bit          acc;
    int          ones;
    st = '0;
    st[3:0] = m_err[3:0];
    st[7:4] = m_good[3:0];
    st[8]   = m_len;
`ifdef JTAG_ER1_PARITY_EN
    st[W] = 1'b1;
`endif
    cyc(1, 0, 0, 0);
    m_armed = 1'b1;
    // Out-stream: the captured status first, then the TDI stream delayed by the register length.
    for (int i = 0; i < n; i++) begin
      exp_bit = (i < LEN) ? st[i] : tx_bits[i-LEN];
      check({tag, ".jtdo1"}, 32'(jtdo1), 32'(exp_bit));
      cyc(1, 1, 0, tx_bits[i]);
    end
    if (do_update) begin
      cyc(0, 0, 1, 0);
      m_armed = 1'b0;
      ones = 0;
      for (int i = 0; i < LEN; i++) ones += int'(tx_bits[i]);
`ifdef JTAG_ER1_PARITY_EN
      acc = (n == LEN) && (ones % 2 == 1);
`else
      acc = (n == LEN);
`endif
      if (acc) begin
        for (int i = 0; i < W; i++) m_data[i] = tx_bits[i];
        m_good = m_good + 8'd1;
        m_len  = 1'b0;
      end else begin
        m_err = m_err + 8'd1;
        m_len = 1'b1;
      end
      check_outs({tag, ".upd"}, acc);
      cyc(0, 0, 0, 0);
      check_outs({tag, ".idle"}, 1'b0);
    end
  endtask

  task automatic stray_update(input string tag);
    cyc(0, 0, 1, 0);
    check_outs(tag, 1'b0);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] d;
    int n;
    jrstn = 1'b0; jce1 = 1'b0; jshift = 1'b0; jupdate = 1'b0; jtdi = 1'b0;
    model_reset();
    @(negedge jtck);
    @(negedge jtck);
    check_outs("reset", 1'b0);
    check("reset.jtdo1", 32'(jtdo1), 32'd0);
    jrstn = 1'b1;
    @(negedge jtck);

    // Basic accepted scan, then readback with no update
    load(16'hA5C3, 1'b0);
    scan("a5c3", LEN, 1'b1);
    check("a5c3.value", 32'(data_out), 32'h0000_A5C3);
    load(16'h0000, 1'b0);
    scan("readback", W, 1'b0);

    // Short scan rejected, then a correct one recovers
    load(16'h0FFF, 1'b0);
    scan("short12", 12, 1'b1);
    check("short12.held", 32'(data_out), 32'h0000_A5C3);
    load(16'h0001, 1'b0);
    scan("one", LEN, 1'b1);

    stray_update("stray1");

    load(16'hFFFF, 1'b0);
    scan("long20", 20, 1'b1);
    load(16'h1357, 1'b0);
    scan("zero", 0, 1'b1);

`ifdef JTAG_ER1_PARITY_EN
    load(16'h0003, 1'b0);
    scan("par_ok", LEN, 1'b1);
    load(16'h0003, 1'b1);
    scan("par_bad", LEN, 1'b1);
`endif

    for (int k = 0; k < 30; k++) begin
      d = 16'($urandom);
      load(d, $urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 3) < 2) ? LEN : int'($urandom_range(0, 30));
      scan("rand", n, 1'b1);
      if ($urandom_range(0, 4) == 0) stray_update("rand_stray");
    end

    // Drive the error counter through a full wrap
    for (int k = 0; k < 256; k++) scan("wrap", 0, 1'b1);

    // Asynchronous reset in the middle of a shift
    load(16'h1234, 1'b0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, tx_bits[i]);
    #2 jrstn = 1'b0;
    #1;
    model_reset();
    check_outs("midrst", 1'b0);
    check("midrst.jtdo1", 32'(jtdo1), 32'd0);
    @(negedge jtck);
    jrstn = 1'b1;
    jce1 = 1'b0; jshift = 1'b0;
    @(negedge jtck);
    stray_update("post_rst_stray");
    load(16'hBEEF, 1'b0);
    scan("post_rst", LEN, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
